// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // States that wait on the memory handshake and are therefore guarded by the timer.
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_wait_timer.sv
// rtl/mips_wait_timer.sv - memory wait counter with clear, enable and terminal count
module mips_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory timeout and sticky error
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       Branch,
    output logic       PCWrite,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic [3:0] state_o,
    output logic       err_o
);

    state_t state_q, state_d;
    logic   err_q, err_d;
    logic   waiting, timeout, timer_tc, timer_clr;

    assign waiting   = is_mem_wait(state_q) && !mem_ready;
    assign timeout   = waiting && timer_tc;
    // A FETCH timeout keeps the state unchanged, so it must clear the counter explicitly.
    assign timer_clr = (state_d != state_q) || timeout;

    mips_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .en  (waiting),
        .tc  (timer_tc)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        Branch   = 1'b0;
        PCWrite  = 1'b0;
        ALUSrcB  = SRCB_REG;
        ALUOp    = ALUOP_ADD;
        PCSrc    = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready && !rst;
                PCWrite = mem_ready && !rst;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                Branch  = 1'b1;
                PCSrc   = PCSRC_ALUOUT;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (timeout) begin
            state_d = S_FETCH;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign state_o = state_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl against an instruction-path model
module tb_mips_multicycle_ctrl;

    localparam int T = 8;

    typedef struct packed {
        logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite;
        logic [1:0] ALUSrcB, ALUOp, PCSrc;
    } ctl_t;

    typedef struct packed {
        logic [3:0] state;
        ctl_t       ctl;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'h00;
    logic       mem_ready = 1'b0;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state_o;
    logic       err_o;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .Branch(Branch), .PCWrite(PCWrite), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .state_o(state_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    ctl_t tbl[12];
    int   checks = 0;
    int   passed = 0;
    int   cycle_no = 0;

    // Model: an instruction is a walk along a fixed list of states chosen at fetch time.
    int   path[$];
    int   pos = 0;
    int   waits = 0;
    logic legal = 1'b1;
    logic merr = 1'b0;

    function automatic ctl_t row(input logic iord, mr, mw, rdst, mtr, rw, srca, br, pcw,
                                 input logic [1:0] srcb, aop, pcs);
        ctl_t c;
        c = '{IorD: iord, MemRead: mr, MemWrite: mw, IRWrite: 1'b0, RegDst: rdst, MemtoReg: mtr,
              RegWrite: rw, ALUSrcA: srca, Branch: br, PCWrite: pcw, ALUSrcB: srcb, ALUOp: aop, PCSrc: pcs};
        return c;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle_no, act, req);
    endfunction

    task automatic advance(input logic [5:0] o, input logic m);
        int cur;
        cur = path[pos];
        if ((cur == 0 || cur == 3 || cur == 5) && !m) begin
            waits++;
            if (waits == T) begin
                merr = 1'b1;
                path = '{0};
                pos = 0;
                waits = 0;
            end
        end else begin
            waits = 0;
            if (cur == 0) begin
                legal = 1'b1;
                case (o)
                    6'h23:   path = '{0, 1, 2, 3, 4};
                    6'h2B:   path = '{0, 1, 2, 5};
                    6'h00:   path = '{0, 1, 6, 7};
                    6'h04:   path = '{0, 1, 8};
                    6'h08:   path = '{0, 1, 9, 10};
                    6'h02:   path = '{0, 1, 11};
                    default: begin path = '{0, 1}; legal = 1'b0; end
                endcase
                pos = 1;
            end else if (pos + 1 < path.size()) begin
                pos++;
            end else begin
                if (cur == 1 && !legal) merr = 1'b1;
                path = '{0};
                pos = 0;
            end
        end
    endtask

    task automatic cyc(input logic [5:0] o, input logic m, input logic r);
        exp_t e;
        @(negedge clk);
        op = o;
        mem_ready = m;
        rst = r;
        if (r) begin
            path = '{0};
            pos = 0;
            waits = 0;
            merr = 1'b0;
        end
        e.state = 4'(path[pos]);
        e.ctl = tbl[path[pos]];
        if (path[pos] == 0) begin
            e.ctl.IRWrite = m && !r;
            e.ctl.PCWrite = m && !r;
        end
        e.err = merr;
        sb.push_back(e);
        if (!r) advance(o, m);
    endtask

    task automatic run(input logic [5:0] o, input int n, input logic m);
        for (int i = 0; i < n; i++) cyc(o, m, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("state", 32'(state_o), 32'(e.state));
                check("ctl", 32'({IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                                  ALUSrcA, Branch, PCWrite, ALUSrcB, ALUOp, PCSrc}), 32'(e.ctl));
                check("err", 32'(err_o), 32'(e.err));
                cycle_no++;
            end
        end
    end

    initial begin : stimulus
        logic [5:0] ops[8];
        logic [5:0] o;
        int stall;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h00};
        path = '{0};
        tbl[0]  = row(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        tbl[1]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
        tbl[2]  = row(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00);
        tbl[3]  = row(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        tbl[4]  = row(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        tbl[5]  = row(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        tbl[6]  = row(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00);
        tbl[7]  = row(0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        tbl[8]  = row(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b01, 2'b01);
        tbl[9]  = row(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00);
        tbl[10] = row(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        tbl[11] = row(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10);

        cyc(6'h00, 1'b1, 1'b1);
        cyc(6'h00, 1'b0, 1'b1);
        run(6'h23, 5, 1'b1);
        run(6'h00, 4, 1'b1);
        run(6'h04, 3, 1'b1);
        run(6'h2B, 3, 1'b1);
        run(6'h2B, 3, 1'b0);
        run(6'h2B, 1, 1'b1);
        run(6'h3F, 2, 1'b1);
        run(6'h02, 3, 1'b1);
        run(6'h08, 4, 1'b1);
        run(6'h23, 3, 1'b1);
        run(6'h23, T, 1'b0);
        run(6'h23, 2, 1'b1);
        cyc(6'h23, 1'b1, 1'b1);
        run(6'h23, 5, 1'b1);
        run(6'h2B, 3, 1'b1);
        run(6'h2B, T - 1, 1'b0);
        run(6'h2B, 1, 1'b1);
        run(6'h00, T, 1'b0);
        run(6'h00, T - 1, 1'b0);
        run(6'h00, 4, 1'b1);

        o = 6'h00;
        stall = 0;
        for (int i = 0; i < 1500; i++) begin
            if (path[pos] == 0) begin
                o = ops[$urandom_range(0, 7)];
                if (o == 6'h00 && $urandom_range(0, 3) == 0) o = 6'($urandom);
            end
            if (stall == 0 && $urandom_range(0, 39) == 0) stall = $urandom_range(T - 2, T + 1);
            if (stall > 0) begin
                stall--;
                cyc(o, 1'b0, 1'b0);
            end else begin
                cyc(o, ($urandom_range(0, 4) != 0), ($urandom_range(0, 99) == 0));
            end
        end

        @(negedge clk);
        #3;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, maximum consecutive not-ready cycles tolerated in a memory wait state.
REQ-002 SHALL use one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 op  input  6  opcode field from the instruction register.
REQ-006 mem_ready  input  1  memory has completed the current access this cycle.
REQ-007 IorD, MemRead, MemWrite, IRWrite  output  1 each  memory address select, read strobe, write strobe and IR load enable.
REQ-008 RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite  output  1 each  datapath controls.
REQ-009 ALUSrcB, ALUOp, PCSrc  output  2 each  ALU B-mux select, ALU decode class and next-PC select.
REQ-010 state_o  output  4  current state encoding, for debug.
REQ-011 err_o  output  1  sticky error flag (illegal opcode or memory timeout).

Function
REQ-012 SHALL register the state; outputs are decoded from the state, with IRWrite and PCWrite in FETCH also qualified by mem_ready; unlisted outputs are 0.
REQ-013 SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-014 SHALL recognise these opcodes: lw=0x23, sw=0x2B, R-type=0x00, beq=0x04, addi=0x08, j=0x02.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, IRWrite=PCWrite=mem_ready; go to DECODE when mem_ready=1, else hold.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state: lw/sw->MEMADR, R->EXECUTE, beq->BRANCH, addi->ADDIEX, j->JUMP, other->FETCH with err_o set.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEMRD for lw, MEMWR for sw.
REQ-018 MEMRD: IorD=1, MemRead=1; go to MEMWB when mem_ready=1, else hold.
REQ-019 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next state FETCH.
REQ-020 MEMWR: IorD=1, MemWrite=1; go to FETCH when mem_ready=1, else hold.
REQ-021 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-022 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next state FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01; next state FETCH.
REQ-024 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state ADDIWB. ADDIWB: RegDst=0, RegWrite=1; next state FETCH.
REQ-025 JUMP: PCSrc=10, PCWrite=1; next state FETCH.
REQ-026 SHALL give these latencies with mem_ready held at 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
REQ-027 Wait counter SHALL increment each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0, and clear on any state change.
REQ-028 If the counter reaches MEM_TIMEOUT-1 while mem_ready=0, SHALL abandon the access, go to FETCH and set err_o; a timeout in FETCH re-enters FETCH with the counter cleared.
REQ-029 mem_ready=1 on the cycle the timeout would fire SHALL win: normal transition, no error.
REQ-030 err_o SHALL stay at 1 until rst and SHALL NOT alter sequencing.

Reset
REQ-031 rst SHALL immediately force state FETCH, wait counter 0 and err_o 0, including mid-instruction.
REQ-032 Held in reset, outputs SHALL show FETCH decode with IRWrite=PCWrite=0 regardless of mem_ready.

Structure
REQ-033 mips_ctrl_pkg SHALL hold the state enum, opcode constants, ALUOp codes (00 add, 01 sub, 10 funct) and PCSrc/ALUSrcB codes.
REQ-034 The wait counter SHALL be a sub-module mips_wait_timer (clear, enable, terminal-count output).

Verification
REQ-035 lw (op=0x23), mem_ready=1 -> states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-036 R-type then beq (op=0x00, then 0x04) -> states 0,1,6,7,0,1,8; ALUOp=10 in EXECUTE, Branch=1 with PCSrc=01 in BRANCH.
REQ-037 sw with mem_ready low 3 cycles in MEMWR -> MemWrite held 4 cycles, then FETCH, err_o=0.
REQ-038 op=0x3F in DECODE -> FETCH next cycle, err_o=1 and stays 1 through a following j (states 1,11,0).
REQ-039 MEMRD with mem_ready=0 for MEM_TIMEOUT cycles -> FETCH, err_o=1; rst pulse mid-MEMADR -> state_o=0 immediately, err_o=0.
